uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ requesters. Round-robin arbitration picks one byte request at a time. The block drives the UART parallel-load interface (P_DATA, PAR_EN, PAR_TYP, DATA_VALID) and tracks Busy until the frame completes. Each requester gets an accept pulse (ack) and a frame-complete pulse (done). It sits between client logic and the UART_TX core, and the existing interface monitor observes its outputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, width of the UART parallel data
BUSY_TIMEOUT, 8, max cycles from DATA_VALID until Busy must rise (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
req  in  NUM_REQ  per-requester transmit request, level, held until ack
req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_par_en  in  NUM_REQ  per-requester parity enable
req_par_typ  in  NUM_REQ  per-requester parity type (0 even, 1 odd)
ack  out  NUM_REQ  one-hot, 1-cycle pulse: byte accepted, requester may change data
done  out  NUM_REQ  one-hot, 1-cycle pulse: frame finished on the line
grant_id  out  $clog2(NUM_REQ)  index of current or last owner
P_DATA  out  DATA_WIDTH  to UART_TX
PAR_EN  out  1  to UART_TX
PAR_TYP  out  1  to UART_TX
DATA_VALID  out  1  to UART_TX, 1-cycle load strobe
Busy  in  1  from UART_TX, high while a frame is shifting

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; ack=0, done=0, DATA_VALID=0, P_DATA=0, PAR_EN=0, PAR_TYP=0, grant_id=0; rr_ptr=NUM_REQ-1, so requester 0 wins first. Reset mid-frame aborts immediately and no done is issued.
- Registered outputs throughout; there is no combinational path from req to any output.
- FSM states:
  - IDLE: if |req && !Busy, pick a winner by searching from rr_ptr+1 upward with wrap. Latch the winner's data, par_en and par_typ into P_DATA, PAR_EN and PAR_TYP. Set grant_id=winner. Assert DATA_VALID and ack[winner] for the next cycle. Go to LAUNCH. If Busy==1 (foreign or leftover frame), stay in IDLE and grant nothing.
  - LAUNCH (1 cycle): DATA_VALID=1 and ack[winner]=1 are visible this cycle. Next cycle both are 0. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for Busy==1, then go to WAIT_DONE. P_DATA, PAR_EN and PAR_TYP stay stable until done.
  - WAIT_DONE: on Busy==0, pulse done[grant_id] for 1 cycle, set rr_ptr=grant_id, go to IDLE.
- Latency: req seen in IDLE at edge N gives DATA_VALID/ack high in cycle N+1. Back-to-back minimum is one IDLE cycle after done before the next DATA_VALID.
- Round-robin: the requester served last has lowest priority next. With all req held high, grant order is 0,1,2,3,0,... Requests not served keep waiting; there is no loss.
- req deasserted after ack: ignored. The frame already latched completes normally.
- req deasserted before selection: no grant.
- Simultaneous done and new req: done is pulsed in the WAIT_DONE to IDLE transition. The new arbitration uses the updated rr_ptr on the following edge.
- At most one bit set in ack, and at most one in done, in any cycle. DATA_VALID is never high while Busy==1.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined: adds output port err (1-bit, reset 0) and a counter in WAIT_BUSY.
  - If Busy has not risen within BUSY_TIMEOUT cycles after LAUNCH, pulse err for 1 cycle. Also pulse done[grant_id] so the requester is released.
  - Then set rr_ptr=grant_id and return to IDLE.
  - The counter clears on entry to WAIT_BUSY.
- Undefined: there is no err port and no counter. WAIT_BUSY waits indefinitely for Busy.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=4'b1111 → all outputs 0, no DATA_VALID. Release reset → first grant_id=0 with P_DATA=req_data[7:0].
- Single request: req=4'b0100, byte 0xA5, PAR_EN=1, PAR_TYP=1; Busy model rises 1 cycle after DATA_VALID and stays high 11 cycles → DATA_VALID exactly 1 cycle, P_DATA=0xA5, PAR_EN=1, PAR_TYP=1, ack[2] in the same cycle, done[2] 1 cycle after Busy falls.
- Round-robin fairness: req=4'b1111 held, bytes 0x10/0x21/0x32/0x43 → grant order 0,1,2,3,0; each done precedes the next DATA_VALID; DATA_VALID never high while Busy=1.
- External busy: Busy=1 in IDLE with req=4'b0001 → no grant until Busy=0, then DATA_VALID on the next cycle.
- Reset mid-frame: assert reset=0 while in WAIT_DONE → no done pulse, outputs 0. After release, pending req=4'b0010 is granted, and req 0 is considered first.
- UART_ARB_TIMEOUT_EN defined: Busy tied 0, req=4'b0001 → err and done[0] pulse exactly BUSY_TIMEOUT cycles after DATA_VALID. The next request is granted normally.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Request/grant and UART parallel-load bundle for uart_tx_arbiter.
// The arbiter takes the slave view; clients and the UART_TX side take the master view.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_par_en;
   logic [NUM_REQ-1:0]            req_par_typ;
   logic [NUM_REQ-1:0]            ack;
   logic [NUM_REQ-1:0]            done;
   logic [$clog2(NUM_REQ)-1:0]    grant_id;
   logic [DATA_WIDTH-1:0]         P_DATA;
   logic                          PAR_EN;
   logic                          PAR_TYP;
   logic                          DATA_VALID;
   logic                          Busy;

   modport slave (
      input  req, req_data, req_par_en, req_par_typ, Busy,
      output ack, done, grant_id, P_DATA, PAR_EN, PAR_TYP, DATA_VALID
   );

   modport master (
      output req, req_data, req_par_en, req_par_typ, Busy,
      input  ack, done, grant_id, P_DATA, PAR_EN, PAR_TYP, DATA_VALID
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte requesters.
// Optional UART_ARB_TIMEOUT_EN adds port err and releases the owner if Busy never rises.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned BUSY_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             reset,
`ifdef UART_ARB_TIMEOUT_EN
   output logic             err,
`endif
   uart_tx_arbiter_if.slave bus
);
   localparam int unsigned GW = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_LAUNCH    = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_TIMEOUT < 2) begin : g_cfg_check
      $error("uart_tx_arbiter: unsupported NUM_REQ or BUSY_TIMEOUT");
   end

   logic [1:0]            r_state;
   logic [GW-1:0]         r_rr_ptr;
   logic [GW-1:0]         r_grant;
   logic [NUM_REQ-1:0]    r_ack;
   logic [NUM_REQ-1:0]    r_done;
   logic [DATA_WIDTH-1:0] r_pdata;
   logic                  r_par_en;
   logic                  r_par_typ;
   logic                  r_dv;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(BUSY_TIMEOUT);
   logic [CW-1:0]         r_cnt;
   logic                  r_err;
   assign err = r_err;
`endif

   logic                  w_found;
   logic [GW-1:0]         w_winner;
   logic [GW-1:0]         w_cand;
   logic [DATA_WIDTH-1:0] w_data;

   // First requester after the last owner, wrapping; the last owner itself is checked last.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_cand = GW'((32'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_found && bus.req[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
      w_data = DATA_WIDTH'(bus.req_data >> (32'(w_winner) * DATA_WIDTH));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= GW'(NUM_REQ - 1);
         r_grant   <= '0;
         r_ack     <= '0;
         r_done    <= '0;
         r_pdata   <= '0;
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
         r_dv      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         r_cnt     <= '0;
         r_err     <= 1'b0;
`endif
      end else begin
         r_ack  <= '0;
         r_done <= '0;
         r_dv   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         r_err  <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_found && !bus.Busy) begin
                  r_pdata   <= w_data;
                  r_par_en  <= bus.req_par_en[w_winner];
                  r_par_typ <= bus.req_par_typ[w_winner];
                  r_grant   <= w_winner;
                  r_ack     <= NUM_REQ'(1) << w_winner;
                  r_dv      <= 1'b1;
                  r_state   <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
`ifdef UART_ARB_TIMEOUT_EN
               r_cnt   <= '0;
`endif
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (bus.Busy) begin
                  r_state <= S_WAIT_DONE;
               end
`ifdef UART_ARB_TIMEOUT_EN
               // Counter starts one cycle after DATA_VALID, hence the -2 for err at +BUSY_TIMEOUT.
               else if (r_cnt == CW'(BUSY_TIMEOUT - 2)) begin
                  r_err    <= 1'b1;
                  r_done   <= NUM_REQ'(1) << r_grant;
                  r_rr_ptr <= r_grant;
                  r_state  <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            S_WAIT_DONE: begin
               if (!bus.Busy) begin
                  r_done   <= NUM_REQ'(1) << r_grant;
                  r_rr_ptr <= r_grant;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ack        = r_ack;
   assign bus.done       = r_done;
   assign bus.grant_id   = r_grant;
   assign bus.P_DATA     = r_pdata;
   assign bus.PAR_EN     = r_par_en;
   assign bus.PAR_TYP    = r_par_typ;
   assign bus.DATA_VALID = r_dv;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios then randomized requesters and UART Busy,
// every cycle checked against a round-robin reference model.
module tb_uart_tx_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned BT = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
`ifdef UART_ARB_TIMEOUT_EN
   logic err;
`endif

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
      .clk   (clk),
      .reset (reset),
`ifdef UART_ARB_TIMEOUT_EN
      .err   (err),
`endif
      .bus   (bus.slave)
   );

   logic [N-1:0]    req_v;
   logic [N-1:0]    pe_v;
   logic [N-1:0]    pt_v;
   logic [N*DW-1:0] dat_v;
   logic            busy_v;

   assign bus.req         = req_v;
   assign bus.req_par_en  = pe_v;
   assign bus.req_par_typ = pt_v;
   assign bus.req_data    = dat_v;
   assign bus.Busy        = busy_v;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   bit          rand_en = 1'b0;
   int unsigned fb_wait = 0, fb_len = 0, fb_left = 0, ext_left = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: tracks frame ownership from observed inputs only.
   bit              m_inflight = 1'b0, m_launch = 1'b0, m_seen = 1'b0;
   int unsigned     m_owner = 0, m_rr = N - 1, m_cnt = 0, m_grant = 0;
   logic [DW-1:0]   m_pd = '0;
   bit              m_pe = 1'b0, m_pt = 1'b0;

   always @(posedge clk) begin
      bit e_dv, e_done, e_err;
      int unsigned w, best, d;
      #1;
      e_dv = 1'b0; e_done = 1'b0; e_err = 1'b0; w = 0;
      if (!reset) begin
         m_inflight = 1'b0; m_launch = 1'b0; m_seen = 1'b0; m_cnt = 0;
         m_rr = N - 1; m_grant = 0; m_pd = '0; m_pe = 1'b0; m_pt = 1'b0;
      end else begin
         if (!m_inflight) begin
            if (req_v != '0 && !busy_v) begin
               // winner = requester at the smallest distance past the last owner
               best = N;
               for (int unsigned i = 0; i < N; i++) begin
                  d = (i + N - m_rr - 1) % N;
                  if (req_v[i] && d < best) begin best = d; w = i; end
               end
               e_dv = 1'b1;
            end
         end else if (!m_launch) begin
            if (m_seen) begin
               if (!busy_v) e_done = 1'b1;
            end else if (busy_v) begin
               m_seen = 1'b1;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else begin
               m_cnt++;
               if (m_cnt == BT - 1) begin e_done = 1'b1; e_err = 1'b1; end
            end
`endif
         end
         m_launch = e_dv;
         if (e_dv) begin
            m_inflight = 1'b1; m_seen = 1'b0; m_cnt = 0;
            m_owner = w; m_grant = w;
            m_pd = dat_v[w*DW +: DW]; m_pe = pe_v[w]; m_pt = pt_v[w];
         end
      end
      check("data_valid", 32'(bus.DATA_VALID), 32'(e_dv));
      check("ack",        32'(bus.ack),        e_dv ? (32'd1 << w) : 32'd0);
      check("done",       32'(bus.done),       e_done ? (32'd1 << m_owner) : 32'd0);
      check("grant_id",   32'(bus.grant_id),   m_grant);
      check("p_data",     32'(bus.P_DATA),     32'(m_pd));
      check("par_en",     32'(bus.PAR_EN),     32'(m_pe));
      check("par_typ",    32'(bus.PAR_TYP),    32'(m_pt));
      check("dv_while_busy", 32'(bus.DATA_VALID && busy_v), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
      check("err",        32'(err),            32'(e_err));
`endif
      if (e_done) begin
         m_inflight = 1'b0;
         m_rr = m_owner;
      end
   end

   // UART_TX stand-in: Busy frame some cycles after each load, plus foreign bursts.
   task automatic busy_model();
      bit skip;
      skip = 1'b0;
      if (bus.DATA_VALID) begin
`ifdef UART_ARB_TIMEOUT_EN
         skip = rand_en && ($urandom_range(3) == 0);
`endif
         if (!skip) begin
            fb_wait = (rand_en ? $urandom_range(3, 1) : 1) + 1;
            fb_len  = rand_en ? $urandom_range(12, 2) : 11;
         end
      end
      if (fb_wait > 0) begin
         fb_wait--;
         if (fb_wait == 0) fb_left = fb_len;
      end
      if (rand_en && ext_left == 0 && fb_wait == 0 && fb_left == 0 && !busy_v
          && $urandom_range(31) == 0)
         ext_left = $urandom_range(4, 1);
      busy_v = (fb_left > 0) || (ext_left > 0);
      if (fb_left > 0)  fb_left--;
      if (ext_left > 0) ext_left--;
   endtask

   task automatic new_req(input int unsigned i);
      req_v[i] = 1'b1;
      dat_v[i*DW +: DW] = DW'($urandom);
      pe_v[i] = 1'($urandom);
      pt_v[i] = 1'($urandom);
   endtask

   task automatic req_model();
      for (int unsigned i = 0; i < N; i++) begin
         if (bus.ack[i]) begin
            if ($urandom_range(1) == 0) req_v[i] = 1'b0;
            else new_req(i);
         end else if (!req_v[i]) begin
            if ($urandom_range(7) == 0) new_req(i);
         end else if ($urandom_range(63) == 0) begin
            req_v[i] = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      busy_model();
      if (rand_en) req_model();
   endtask

   task automatic wait_evt(input bit is_done, input int unsigned idx, input string tag);
      int unsigned n;
      bit hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < 300) begin
         tick();
         n++;
         hit = is_done ? bus.done[idx] : bus.ack[idx];
      end
      check(tag, 32'(hit), 32'd1);
   endtask

   initial begin
      int unsigned n, k;
      busy_v = 1'b0;
      req_v  = '1;
      dat_v  = 32'h4332_2110;
      pe_v   = 4'b0101;
      pt_v   = 4'b0011;
      reset  = 1'b0;
      repeat (3) tick();
      reset = 1'b1;

      n = 0;
      k = 0;
      while (n < 5 && k < 500) begin
         tick();
         k++;
         if (bus.done != '0) n++;
      end
      check("rr_frames", n, 5);
      req_v = '0;
      repeat (4) tick();

      dat_v[2*DW +: DW] = 8'hA5;
      pe_v[2] = 1'b1;
      pt_v[2] = 1'b1;
      req_v = 4'b0100;
      wait_evt(1'b0, 2, "ack2_single");
      req_v[2] = 1'b0;
      wait_evt(1'b1, 2, "done2_single");
      repeat (2) tick();

      ext_left = 6;
      tick();
      req_v = 4'b0001;
      wait_evt(1'b0, 0, "ack0_ext_busy");
      req_v[0] = 1'b0;
      wait_evt(1'b1, 0, "done0_ext_busy");
      repeat (2) tick();

      req_v = 4'b0001;
      wait_evt(1'b0, 0, "ack0_pre_reset");
      req_v = 4'b0010;
      repeat (4) tick();
      reset = 1'b0;
      req_v = 4'b0011;
      repeat (2) tick();
      reset = 1'b1;
      wait_evt(1'b0, 0, "ack0_post_reset");
      req_v[0] = 1'b0;
      wait_evt(1'b0, 1, "ack1_post_reset");
      req_v[1] = 1'b0;
      wait_evt(1'b1, 1, "done1_post_reset");

      rand_en = 1'b1;
      repeat (4000) tick();
      rand_en = 1'b0;
      req_v = '0;
      repeat (60) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
